uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//  - UART transmitter for the pipeline core: outbound side of the serial link whose receive side loads programs.
//  - Core stores bytes into a small FIFO; block serialises them 8N1 (optional parity), LSB first, on tx.
//  - Sits between the core's MMIO store path and the top-level tx pad.
// PARAMETERS
//  - CLK_FREQ    50_000_000  system clock frequency, Hz
//  - BAUD        115_200     line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, must be >= 2)
//  - FIFO_DEPTH  8           byte slots; power of 2, >= 2
// PORTS
//  - clk         in   1                  system clock, rising edge
//  - reset       in   1                  synchronous, active-high
//  - wr_data     in   8                  byte to transmit
//  - wr_valid    in   1                  write request; accepted when wr_valid && wr_ready
//  - wr_ready    out  1                  FIFO not full
//  - tx          out  1                  serial line, idle high, registered
//  - busy        out  1                  FIFO non-empty or frame in progress
//  - fifo_count  out  $clog2(DEPTH)+1    bytes waiting (frame in flight excluded)
// BEHAVIOUR
//  - Clock is clk; reset is synchronous and active-high on reset. All state updates on rising edge.
//  - Reset: tx=1, wr_ready=1, busy=0, fifo_count=0, FSM=IDLE, baud counter=0, bit index=0.
//  - Reset mid-frame aborts immediately: tx=1 next cycle, FIFO flushed; no partial frame resumes.
//  - wr_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
//  - Write with wr_ready=0 is dropped; contents and count unchanged.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    - IDLE: if fifo_count != 0, pop head into shift reg, go START, tx<=0 at the same edge.
//    - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
//    - DATA: bit i on tx for CLKS_PER_BIT cycles; i = 0..7, LSB first; after bit 7, PARITY or STOP.
//    - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
//  - Baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on each bit transition.
//  - Latency: push at edge N into empty FIFO while IDLE -> pop at edge N+1 -> tx low from N+1 onward.
//  - Back-to-back: IDLE with non-empty FIFO pops on the first IDLE cycle, giving exactly 1 extra idle-high cycle between frames.
//  - Simultaneous push and pop:
//    - Count unchanged; pointers both advance, wrapping modulo FIFO_DEPTH.
//    - Full FIFO: wr_ready=0 that cycle, so only the pop occurs.
//    - Empty FIFO: no pop; pushed byte is popped next cycle.
//  - busy = (state != IDLE) || (fifo_count != 0).
// CONFIGURATION
//  - UART_TX_PARITY_EN defined:
//    - PARITY state after bit 7; tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
//    - Frame is 11 bits.
//  - UART_TX_PARITY_EN undefined: no PARITY state; frame is 10 bits (8N1).
// STRUCTURE
//  - Shared package uart_pkg:
//    - FSM state encoding typedef tx_state_t (IDLE, START, DATA, PARITY, STOP).
//    - Constants UART_DATA_BITS=8, UART_IDLE_LEVEL=1'b1.
//    - Function clks_per_bit(clk_freq, baud).
//  - Sub-module uart_tx_fifo:
//    - Synchronous FIFO with registered count, push/pop/full/empty.
//    - Read data is combinational from the head slot.
//  - Top level holds the FSM, baud counter, bit index and shift register.
// TESTING  (CLK_FREQ=1_000_000, BAUD=100_000 -> CLKS_PER_BIT=10)
//  - Single byte 0xA5 pushed at cycle 0 -> tx falls at cycle 1; 10-cycle bits sample 0,1,0,1,0,0,1,0,1,1;
//    busy low at cycle 101; tx high throughout after.
//  - Push 0x00,0xFF,0x55 on consecutive cycles -> three frames; each idle gap is exactly 1 cycle;
//    fifo_count goes 1,1,2 then falls by 1 at each frame start.
//  - Push 9 bytes with tx stalled in a frame (DEPTH=8) -> wr_ready=0 after 8 accepted;
//    9th byte dropped; 8 frames emitted, no 9th.
//  - Full FIFO, pop edge coincides with wr_valid -> write rejected; count 8->7; next-cycle write accepted (count 8).
//  - Assert reset for 1 cycle mid-DATA of 0x3C with 3 bytes queued -> tx=1, busy=0, fifo_count=0 next cycle;
//    no further start bits.
//  - UART_TX_PARITY_EN defined, byte 0x07 -> parity bit 1 after bit 7, then stop; frame spans 110 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and
// the baud divider helper.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART serialiser: registered count, wrapping
// pointers, head slot readable combinationally.
module uart_tx_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is dropped; a pop from an empty one is ignored.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed 8N1 serialiser, LSB first, idle-high tx.
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frames).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter  int CLK_FREQ   = 50_000_000,
  parameter  int BAUD       = 115_200,
  parameter  int FIFO_DEPTH = 8,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic          tx,
  output logic          busy,
  output logic [CW-1:0] fifo_count
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic [7:0]       fifo_rd_data;
  logic             fifo_full, fifo_empty, fifo_pop, bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  assign fifo_pop = (state_q == IDLE) && !fifo_empty;
  assign bit_end  = (cnt_q == CNT_LAST);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (wr_valid),
    .wr_data_i (wr_data),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign wr_ready = !fifo_full;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign tx       = tx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          // Start bit goes out on the same edge that pops the head byte.
          if (!fifo_empty) begin
            shift_q <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^fifo_rd_data;
`endif
            tx_q    <= 1'b0;
            state_q <= START;
          end else begin
            tx_q <= UART_IDLE_LEVEL;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= PARITY;
`else
              tx_q    <= UART_IDLE_LEVEL;
              state_q <= STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= UART_IDLE_LEVEL;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          tx_q    <= UART_IDLE_LEVEL;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: directed scenarios plus random
// traffic, all checked every cycle against a frame-timeline reference model.
module tb_uart_tx_buffered;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;

  uart_tx_buffered #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of waiting bytes plus the span of the frame in flight.
  logic [7:0] q_model[$];
  longint     e = 0;
  bit         have_frame = 0;
  longint     f_start = 0;
  longint     f_end = 0;
  logic [7:0] f_byte = 8'h00;

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, e);
      if (n_errors >= 50) finish_sim();
    end
  endtask

  function automatic logic exp_tx();
    int pos;
    if (have_frame && e >= f_start && e < f_end) begin
      pos = int'((e - f_start) / CPB);
      if (pos == 0) return 1'b0;
      if (pos <= 8) return f_byte[pos-1];
`ifdef UART_TX_PARITY_EN
      if (pos == 9) return ^f_byte;
`endif
      return 1'b1;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit idle_pre;
    int pre_size;
    if (reset) begin
      q_model.delete();
      have_frame = 0;
      return;
    end
    idle_pre = !have_frame || (e - 1 >= f_end);
    pre_size = q_model.size();
    if (idle_pre && pre_size > 0) begin
      f_byte     = q_model.pop_front();
      f_start    = e;
      f_end      = e + FRAME_CYC;
      have_frame = 1;
    end
    if (wr_valid && pre_size != DEPTH) q_model.push_back(wr_data);
  endtask

  task automatic step();
    logic exp_busy;
    @(posedge clk);
    e++;
    model_edge();
    #1;
    exp_busy = (have_frame && e < f_end) || (q_model.size() != 0);
    check("tx", {31'd0, tx}, {31'd0, exp_tx()});
    check("busy", {31'd0, busy}, {31'd0, exp_busy});
    check("fifo_count", {28'd0, fifo_count}, 32'(q_model.size()));
    check("wr_ready", {31'd0, wr_ready}, {31'd0, q_model.size() != DEPTH});
  endtask

  task automatic push(input logic [7:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      step();
      n++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    longint push_edge;
    int     n;
    int     acc;
    int     lows;
    int     dens;
    logic [3:0] cnt_seen [3];
    logic [7:0] t2_bytes [3];

    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    step();
    step();
    reset = 1'b0;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {28'd0, fifo_count}, 32'd0);
    check("rst_ready", {31'd0, wr_ready}, 32'd1);
    step();

    // Single byte: start bit one edge after the push, line idle again after one frame.
    push(8'hA5);
    push_edge = e;
    n = 0;
    while (tx !== 1'b0 && n < 20) begin step(); n++; end
    check("t1_fall", 32'(e - push_edge), 32'd1);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin step(); n++; end
    check("t1_busy_low", 32'(e - push_edge), 32'(FRAME_CYC + 1));
    repeat (20) step();

    // Three back-to-back pushes.
    t2_bytes[0] = 8'h00; t2_bytes[1] = 8'hFF; t2_bytes[2] = 8'h55;
    for (int i = 0; i < 3; i++) begin
      wr_data  = t2_bytes[i];
      wr_valid = 1'b1;
      step();
      cnt_seen[i] = fifo_count;
    end
    wr_valid = 1'b0;
    check("t2_cnt0", {28'd0, cnt_seen[0]}, 32'd1);
    check("t2_cnt1", {28'd0, cnt_seen[1]}, 32'd1);
    check("t2_cnt2", {28'd0, cnt_seen[2]}, 32'd2);
    wait_idle(4 * FRAME_CYC);
    step();

    // Overflow: nine pushes while a frame is in flight.
    push(8'h11);
    repeat (3) step();
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      wr_data  = 8'($urandom);
      wr_valid = 1'b1;
      if (wr_ready) acc++;
      step();
    end
    check("t3_accepted", 32'(acc), 32'd8);
    check("t3_ready", {31'd0, wr_ready}, 32'd0);
    check("t3_count", {28'd0, fifo_count}, 32'd8);

    // Keep writing across the pop edge of a full FIFO.
    wr_data = 8'hC3;
    n = 0;
    while (fifo_count == 4'd8 && n < 2 * FRAME_CYC) begin step(); n++; end
    check("t4_drop", {28'd0, fifo_count}, 32'd7);
    step();
    check("t4_refill", {28'd0, fifo_count}, 32'd8);
    wr_valid = 1'b0;
    wait_idle(10 * FRAME_CYC + 100);
    step();

    // Reset in the middle of the data bits of 0x3C with three bytes queued.
    push(8'h3C);
    push(8'h81);
    push(8'h42);
    push(8'hE7);
    repeat (30) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_tx", {31'd0, tx}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_count", {28'd0, fifo_count}, 32'd0);
    lows = 0;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      step();
      if (tx !== 1'b1) lows++;
    end
    check("t5_quiet", 32'(lows), 32'd0);

    // Random traffic at varying densities with rare resets.
    dens = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        case ($urandom_range(0, 3))
          0:       dens = 2;
          1:       dens = 10;
          2:       dens = 40;
          default: dens = 90;
        endcase
      end
      wr_valid = ($urandom_range(0, 99) < dens);
      wr_data  = 8'($urandom);
      reset    = ($urandom_range(0, 1999) == 0);
      step();
    end
    wr_valid = 1'b0;
    reset    = 1'b0;
    wait_idle((DEPTH + 2) * FRAME_CYC);
    repeat (5) step();

    finish_sim();
  end

endmodule
